// File: rtl/press_classifier.sv
// Button gesture classifier: single, double and long press
// from a synchronized level plus its rising-edge pulse.
module press_classifier #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 10,
  parameter int GAP_CYCLES      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic btn_rise,
  output logic single_press,
  output logic double_press,
  output logic long_press,
  output logic busy
);

  localparam int MAX_DL =
    (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_C =
    (MAX_DL > GAP_CYCLES) ? MAX_DL : GAP_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] DEB_END  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB1,
    HELD,
    GAP,
    DEB2,
    WAIT_REL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_rise) begin
            state <= DEB1;
            cnt   <= '0;
          end
        end
        DEB1: begin
          if (!btn_level) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_END) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_level) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_END) begin
            state      <= WAIT_REL;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // a rise on the terminal count still wins
          if (btn_rise) begin
            state <= DEB2;
            cnt   <= '0;
          end else if (cnt == GAP_END) begin
            state        <= IDLE;
            cnt          <= '0;
            single_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEB2: begin
          if (!btn_level) begin
            state        <= IDLE;
            cnt          <= '0;
            single_press <= 1'b1;
          end else if (cnt == DEB_END) begin
            state        <= WAIT_REL;
            cnt          <= '0;
            double_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!btn_level) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier: gesture table
// plus a hand-written ignored-rise sequence.
module tb_press_classifier;

  logic clk = 1'b0;
  logic rst;
  logic btn_level;
  logic btn_rise;
  logic single_press;
  logic double_press;
  logic long_press;
  logic busy;

  int checks = 0;
  int errors = 0;

  press_classifier #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(10),
    .GAP_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .single_press(single_press),
    .double_press(double_press),
    .long_press(long_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // level high in [r1,f1) and [r2,f2); rise derived from level
  typedef struct {
    string name;
    int r1;
    int f1;
    int r2;
    int f2;
    int rst_c;
    int es;
    int ed;
    int el;
    int boff;
  } vec_t;

  localparam int NCYC = 45;

  vec_t vecs[12];

  function automatic logic lvl(vec_t v, int c);
    return (c >= v.r1 && c < v.f1) || (c >= v.r2 && c < v.f2);
  endfunction

  task automatic chk(string nm, int c, logic [3:0] got,
                     logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b want %b",
               nm, c, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    btn_level = 1'b0;
    btn_rise  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"long",      0, 21, -1, -1, -1, -1, -1, 15, 22};
    vecs[1]  = '{"single",    0,  8, -1, -1, -1, 15, -1, -1, 15};
    vecs[2]  = '{"double",    0,  8, 11, 21, -1, -1, 16, -1, 22};
    vecs[3]  = '{"glitch",    0,  3, -1, -1, -1, -1, -1, -1,  4};
    vecs[4]  = '{"gap_edge",  0,  8, 14, 25, -1, -1, 19, -1, 26};
    vecs[5]  = '{"rst_mid",   0, 11, 12, 35, 10, -1, -1, 27, 11};
    vecs[6]  = '{"dbl_hold",  0,  8, 11, 40, -1, -1, 16, -1, 41};
    vecs[7]  = '{"deb2_bnc",  0,  8, 11, 13, -1, 14, -1, -1, 14};
    vecs[8]  = '{"deb1_last", 0,  4, -1, -1, -1, -1, -1, -1,  5};
    vecs[9]  = '{"held_1st",  0,  5, -1, -1, -1, 12, -1, -1, 12};
    vecs[10] = '{"long_edge", 0, 15, -1, -1, -1, -1, -1, 15, 16};
    vecs[11] = '{"pre_long",  0, 14, -1, -1, -1, 21, -1, -1, 21};

    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v = vecs[i];
      do_reset();
      for (int c = 0; c < NCYC; c++) begin
        logic [3:0] got;
        logic [3:0] exp;
        btn_level = lvl(v, c);
        btn_rise  = lvl(v, c) && (c == 0 || !lvl(v, c - 1));
        rst       = (c == v.rst_c);
        got = {single_press, double_press, long_press, 1'b0};
        exp = {c == v.es, c == v.ed, c == v.el, 1'b0};
        chk({v.name, "_pulse"}, c, got, exp);
        if (c == 0)
          chk({v.name, "_rstbusy"}, c, {3'b0, busy}, 4'b0);
        if (c == v.boff - 1)
          chk({v.name, "_busy_hi"}, c, {3'b0, busy}, 4'b1);
        if (c == v.boff)
          chk({v.name, "_busy_lo"}, c, {3'b0, busy}, 4'b0);
        @(posedge clk);
        #1;
      end
    end

    // extra rises in DEB1, HELD and WAIT_REL must be ignored
    do_reset();
    for (int c = 0; c < 24; c++) begin
      logic [3:0] got;
      logic [3:0] exp;
      logic eb;
      btn_level = (c < 20);
      btn_rise  = (c == 0 || c == 2 || c == 7 || c == 17);
      got = {single_press, double_press, long_press, busy};
      eb  = (c >= 1 && c <= 20);
      exp = {1'b0, 1'b0, c == 15, eb};
      chk("ign_rise", c, got, exp);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
